// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state type and default lock limit shared by mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int LOCK_MAX_DEF = 16;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter with bounded locking onto one single-port RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_ren,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  state_t state_q;
  logic last_q, lock_q, we_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic hold, win, win_lock, keep;
  // last_q doubles as the owner: it names whoever holds the current or most recent grant
  always_comb begin
    hold = lock_q && (last_q ? m1_req && m1_lock : m0_req && m0_lock) && cnt_q < LMAX;
    win = m1_req && (!m0_req || (hold ? last_q : !last_q));
    win_lock = win ? m1_lock : m0_lock;
    keep = lock_q && win == last_q;
    cnt_d = !win_lock ? '0 : !keep ? CW'(1) : cnt_q == LMAX ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (m0_req || m1_req) begin
          state_q <= ACCESS;
          last_q  <= win;
          lock_q  <= win_lock;
          cnt_q   <= cnt_d;
          we_q    <= win ? m1_we : m0_we;
          addr_q  <= win ? m1_addr : m0_addr;
          wdata_q <= win ? m1_wdata : m0_wdata;
          wmask_q <= win ? m1_wmask : m0_wmask;
        end
        ACCESS: state_q <= we_q ? IDLE : RESP;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign m0_gnt    = state_q == ACCESS && !last_q;
  assign m1_gnt    = state_q == ACCESS && last_q;
  assign m0_rvalid = state_q == RESP && !last_q;
  assign m1_rvalid = state_q == RESP && last_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ren   = state_q == ACCESS && !we_q;
  assign mem_wmask = state_q == ACCESS && we_q ? wmask_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner sequences, then random two-master traffic
// checked against a grant-history reference model and a shadow memory
module tb_mem_arbiter;
  localparam int LM = 4;
  typedef struct { int m; bit we; logic [31:0] a; logic [31:0] d; logic [3:0] mk; logic [31:0] ex; } vec_t;
  typedef struct { int who; bit lk; } h_t;

  logic CLK = 0, RESET = 1;
  logic [1:0] req = 0, lock = 0, we = 0, gnt, rvalid;
  logic [31:0] addr [2] = '{default: 0};
  logic [31:0] wdata [2] = '{default: 0};
  logic [3:0] mask [2] = '{default: 0};
  logic [31:0] rdata [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wmask;
  logic mem_ren;
  logic [31:0] ram [64] = '{16: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] shadow [64] = '{default: 32'h0};
  logic [1:0] req_e = 0, lock_e = 0, we_e = 0, pend = 0;
  logic [31:0] addr_e [2], wdata_e [2], exp_rd [2];
  logic [3:0] mask_e [2];
  h_t hist [$];
  bit mon_en = 0;
  int total = 0, bad = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .CLK(CLK), .RESET(RESET),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_wmask(mask[0]), .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_wmask(mask[1]), .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_ren) mem_rdata <= ram[mem_addr[5:0]];
    for (int b = 0; b < 4; b++) if (mem_wmask[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", n, got, exp);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_gnt"}, gnt, 0);
    chk({n, "_rvalid"}, rvalid, 0);
    chk({n, "_mem_ren"}, mem_ren, 0);
    chk({n, "_mem_wmask"}, mem_wmask, 0);
    chk({n, "_mem_addr"}, mem_addr, 0);
    chk({n, "_mem_wdata"}, mem_wdata, 0);
    chk({n, "_rdata0"}, rdata[0], 0);
    chk({n, "_rdata1"}, rdata[1], 0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
  endtask

  // one isolated transaction: gnt one cycle after the request, read data one cycle later
  task automatic txn(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] mk, input logic [31:0] ex, input string n);
    int gc, rc;
    logic [31:0] rd;
    gc = -1; rc = -1; rd = 0;
    @(negedge CLK);
    we[m] = w; addr[m] = a; wdata[m] = d; mask[m] = mk; lock[m] = 0; req[m] = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (gnt[m] && gc < 0) begin
        gc = c;
        req[m] = 0;
        chk({n, "_ren"}, mem_ren, !w);
        chk({n, "_wmask"}, mem_wmask, w ? mk : 4'h0);
        chk({n, "_addr"}, mem_addr, a);
        chk({n, "_other_gnt"}, gnt[1-m], 0);
        chk({n, "_rdata_early"}, rdata[m], 0);
      end
      if (rvalid[m]) begin
        rc = c;
        rd = rdata[m];
        chk({n, "_other_rdata"}, rdata[1-m], 0);
      end
    end
    chk({n, "_gnt_cycle"}, gc, 1);
    chk({n, "_rvalid_cycle"}, rc, w ? -1 : 2);
    if (!w) chk({n, "_rdata"}, rd, ex);
  endtask

  // reference arbitration from the grant history: a locked streak shorter than LM keeps the owner
  function automatic int pick();
    int lw = hist.size() == 0 ? 1 : hist[$].who;
    int s = 0;
    if (!req_e[1]) return 0;
    if (!req_e[0]) return 1;
    for (int i = hist.size() - 1; i >= 0 && hist[i].who == lw && hist[i].lk; i--) s++;
    return (s > 0 && s < LM && lock_e[lw]) ? lw : 1 - lw;
  endfunction

  task automatic monitor();
    int e, a;
    chk("rvalid", rvalid, pend);
    for (int m = 0; m < 2; m++) chk($sformatf("rdata%0d", m), rdata[m], rvalid[m] ? exp_rd[m] : 32'h0);
    pend = 0;
    if (gnt != 0) begin
      e = pick();
      a = int'(addr_e[e][5:0]);
      chk("gnt", gnt, e ? 2'b10 : 2'b01);
      chk("mem_addr", mem_addr, addr_e[e]);
      chk("mem_ren", mem_ren, !we_e[e]);
      chk("mem_wmask", mem_wmask, we_e[e] ? mask_e[e] : 4'h0);
      if (we_e[e]) begin
        chk("mem_wdata", mem_wdata, wdata_e[e]);
        for (int b = 0; b < 4; b++) if (mask_e[e][b]) shadow[a][8*b +: 8] = wdata_e[e][8*b +: 8];
      end else begin
        exp_rd[e] = shadow[a];
        pend[e] = 1'b1;
      end
      hist.push_back('{e, lock_e[e]});
    end else begin
      chk("idle_ren", mem_ren, 0);
      chk("idle_wmask", mem_wmask, 0);
    end
  endtask

  task automatic master(input int m, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      we[m] = 1'($urandom_range(0, 1));
      addr[m] = 32'h30 + $urandom_range(0, 15);
      wdata[m] = $urandom;
      mask[m] = 4'($urandom_range(1, 15));
      lock[m] = $urandom_range(0, 3) != 0;
      req[m] = 1;
      w = 0;
      do begin @(negedge CLK); w++; end while (!gnt[m] && w < 200);
      chk($sformatf("m%0d_grant_wait", m), gnt[m], 1);
      req[m] = 0;
      if (!we[m]) @(negedge CLK);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    req_e = req; lock_e = lock; we_e = we;
    for (int m = 0; m < 2; m++) begin
      addr_e[m] = addr[m]; wdata_e[m] = wdata[m]; mask_e[m] = mask[m];
    end
  end

  initial forever begin
    @(negedge CLK);
    if (mon_en) monitor();
  end

  initial begin
    vec_t tv [6];
    int got [10];
    int lx [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n, w;
    bit started;
    tv[0] = '{0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF};
    tv[1] = '{1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0};
    tv[2] = '{0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678};
    tv[3] = '{1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0};
    tv[4] = '{1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12BB56DD};
    tv[5] = '{0, 1'b0, 32'h11, 32'h0, 4'h0, 32'h0};
    @(negedge CLK);
    chk_zero("reset");
    RESET = 0;
    for (int i = 0; i < 6; i++) txn(tv[i].m, tv[i].we, tv[i].a, tv[i].d, tv[i].mk, tv[i].ex, $sformatf("v%0d", i));

    // both masters reading back to back, unlocked
    pulse_reset();
    for (int i = 0; i < 10; i++) got[i] = -1;
    we = 0; lock = 0; addr[0] = 32'h10; addr[1] = 32'h10; req = 2'b11;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge CLK);
      for (int m = 0; m < 2; m++) begin
        if (gnt[m]) begin got[n] = m; n++; req[m] = 0; end
        if (rvalid[m]) req[m] = 1;
      end
    end
    req = 0;
    chk("rr_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr%0d", i), got[i], i % 2);

    // m1 locked writer, m0 reader waiting
    repeat (4) @(negedge CLK);
    pulse_reset();
    for (int i = 0; i < 10; i++) got[i] = -1;
    we = 2'b10; lock = 2'b10; addr[1] = 32'h21; wdata[1] = 32'hCAFE0000; mask[1] = 4'hF;
    addr[0] = 32'h10; req = 2'b10;
    n = 0; started = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge CLK);
      if (gnt[1]) begin
        got[n] = 1; n++;
        if (!started) begin req[0] = 1; started = 1; end
      end
      if (gnt[0]) begin got[n] = 0; n++; req[0] = 0; end
      if (rvalid[0]) req[0] = 1;
    end
    req = 0; lock = 0;
    chk("lock_count", n, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("lock%0d", i), got[i], lx[i]);

    // reset in the middle of a read access
    repeat (4) @(negedge CLK);
    we = 0; addr[0] = 32'h10; req[0] = 1;
    w = 0;
    do begin @(negedge CLK); w++; end while (!gnt[0] && w < 10);
    chk("rst_gnt", gnt[0], 1);
    req[0] = 0;
    #1 RESET = 1;
    #1 chk_zero("mid_rst");
    @(negedge CLK);
    RESET = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("rst_no_rvalid", rvalid, 0);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, "post_rst");

    // randomized traffic against the reference model
    pulse_reset();
    hist.delete();
    pend = 0;
    mon_en = 1;
    fork
      master(0, 60);
      master(1, 60);
    join
    repeat (4) @(negedge CLK);
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
